// File: rtl/recip_nr_refine_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : recip_nr_refine_if
//  Purpose  : Operand/result handshake bundle for the reciprocal refine stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface recip_nr_refine_if #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
);
    localparam int c_NW = NEXP + NSIG + 1;

    logic            in_valid;
    logic            in_ready;
    logic [c_NW-1:0] A;
    logic [c_NW-1:0] Aseed;
    logic [5:0]      seedFlags;
    logic            out_valid;
    logic            out_ready;
    logic [c_NW-1:0] Arecip;
    logic [5:0]      recipFlags;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, A, Aseed, seedFlags, out_ready,
        input  in_ready, out_valid, Arecip, recipFlags
    );

    // Refinement stage side.
    modport slave (
        input  in_valid, A, Aseed, seedFlags, out_ready,
        output in_ready, out_valid, Arecip, recipFlags
    );
endinterface
`default_nettype wire

// File: rtl/recip_nr_refine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : recip_nr_refine
//  Purpose  : Newton-Raphson refinement of a bfloat16 reciprocal seed with
//             round-to-nearest-even output over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module recip_nr_refine #(
    parameter int NEXP  = 8,
    parameter int NSIG  = 7,
    parameter int ITERS = 2,
    parameter int GUARD = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    recip_nr_refine_if.slave  bus
);
    localparam int c_W   = NSIG + 1 + GUARD;
    localparam int c_NW  = NEXP + NSIG + 1;
    localparam int c_ITW = $clog2(ITERS) + 1;

    // 2*bias-1 and 2*bias as NEXP-bit patterns (253 / 254 for NEXP=8).
    localparam logic [NEXP-1:0] c_ELIM = {{(NEXP-2){1'b1}}, 2'b01};
    localparam logic [NEXP-1:0] c_TWOB = {{(NEXP-1){1'b1}}, 1'b0};
    localparam logic [c_W+1:0]  c_TWO  = {2'b10, {c_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_P     = 3'd1,
        S_X     = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_ITW-1:0]  r_iter;
    logic [NSIG:0]     r_b;
    logic [c_W-1:0]    r_x;
    logic [c_W:0]      r_p;
    logic              r_sign;
    logic [NEXP-1:0]   r_ea;
    logic [c_NW-1:0]   r_arecip;
    logic [5:0]        r_flags;

    logic              w_accept;
    logic              w_refine;
    logic [NEXP-1:0]   w_in_ea;
    logic [NSIG-1:0]   w_in_fa;
    logic [NSIG+c_W:0] w_bx;
    logic [c_W:0]      w_p;
    logic [c_W+1:0]    w_e_full;
    logic [2*c_W:0]    w_xe;
    logic [c_W-1:0]    w_xnew;
    logic [NSIG-1:0]   w_frac;
    logic              w_lsb;
    logic              w_guard;
    logic              w_sticky;
    logic              w_up;
    logic [NSIG:0]     w_rnd;
    logic [NEXP-1:0]   w_eres;
    logic              w_unused;

    assign w_in_ea  = bus.A[c_NW-2:NSIG];
    assign w_in_fa  = bus.A[NSIG-1:0];
    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    // Only finite normals with a clean seed and a normal reciprocal get refined.
    assign w_refine = (w_in_ea != '0) && (w_in_ea != '1) && (w_in_fa != '0) &&
                      (bus.seedFlags == 6'd0) && (w_in_ea < c_ELIM);

    // P step: p = b*x with b carrying NSIG fractional bits, truncated to W.
    assign w_bx     = r_b * r_x;
    assign w_p      = w_bx[NSIG+c_W:NSIG];
    // X step: e = 2 - p, x = x*e truncated; x stays below 1 so bit 2W is zero.
    assign w_e_full = c_TWO - {1'b0, r_p};
    assign w_xe     = r_x * w_e_full[c_W:0];
    assign w_xnew   = w_xe[2*c_W-1:c_W];

    // x is in (0.5,1): bit W-1 is the hidden one, next NSIG bits the fraction.
    assign w_frac   = r_x[c_W-2:c_W-1-NSIG];
    assign w_lsb    = r_x[c_W-1-NSIG];
    assign w_guard  = r_x[c_W-2-NSIG];
    assign w_sticky = |r_x[c_W-3-NSIG:0];
    assign w_up     = w_guard && (w_sticky || w_lsb);
    assign w_rnd    = {1'b0, w_frac} + {{NSIG{1'b0}}, w_up};
    assign w_eres   = w_rnd[NSIG] ? (c_TWOB - r_ea) : (c_ELIM - r_ea);

    assign w_unused = ^{w_bx[NSIG-1:0], w_xe[2*c_W], w_xe[c_W-1:0],
                        w_e_full[c_W+1], r_x[c_W-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_refine ? S_P : S_DONE;
                end
            end
            S_P: begin
                w_state_nxt = S_X;
            end
            S_X: begin
                w_state_nxt = (r_iter == c_ITW'(ITERS - 1)) ? S_ROUND : S_P;
            end
            S_ROUND: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter   <= '0;
            r_b      <= '0;
            r_x      <= '0;
            r_p      <= '0;
            r_sign   <= 1'b0;
            r_ea     <= '0;
            r_arecip <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_iter <= '0;
                        r_b    <= {1'b1, w_in_fa};
                        r_x    <= {1'b1, bus.Aseed[NSIG-1:0], {GUARD{1'b0}}};
                        r_sign <= bus.A[c_NW-1];
                        r_ea   <= w_in_ea;
                        if (!w_refine) begin
                            r_arecip <= bus.Aseed;
                            r_flags  <= bus.seedFlags;
                        end
                    end
                end
                S_P: begin
                    r_p <= w_p;
                end
                S_X: begin
                    r_x    <= w_xnew;
                    r_iter <= r_iter + c_ITW'(1);
                end
                S_ROUND: begin
                    r_arecip <= {r_sign, w_eres, w_rnd[NSIG-1:0]};
                    r_flags  <= 6'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.Arecip     = r_arecip;
    assign bus.recipFlags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_recip_nr_refine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_recip_nr_refine
//  Purpose  : Self-checking bench: directed cases plus randomized operands
//             compared against an arithmetic reference of the refinement.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_recip_nr_refine;
    localparam int c_ITERS = 2;
    localparam int c_W     = 16;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    recip_nr_refine_if #(.NEXP(8), .NSIG(7)) bus ();

    recip_nr_refine #(.NEXP(8), .NSIG(7), .ITERS(c_ITERS), .GUARD(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit refine_ok(input logic [15:0] a, input logic [5:0] f);
        int ea;
        ea = int'(a[14:7]);
        return (ea >= 1) && (ea <= 254) && (a[6:0] != 7'd0) && (f == 6'd0) && (ea < 253);
    endfunction

    // Iterate x <- x(2 - b x) in integer fixed point, then round to nearest even.
    function automatic logic [15:0] ref_refine(input logic [15:0] a, input logic [15:0] s);
        longint b, x, p, e, frac, rem;
        int     ea, er;
        b  = 128 + longint'(a[6:0]);
        x  = (128 + longint'(s[6:0])) * 256;
        ea = int'(a[14:7]);
        for (int i = 0; i < c_ITERS; i++) begin
            p = (b * x) / 128;
            e = (longint'(2) << c_W) - p;
            x = (x * e) >> c_W;
        end
        frac = (x / 256) % 128;
        rem  = x % 256;
        if (rem > 128 || (rem == 128 && (frac % 2) == 1)) frac = frac + 1;
        er = 253 - ea;
        if (frac == 128) begin
            frac = 0;
            er   = 254 - ea;
        end
        return {a[15], 8'(er), 7'(frac)};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] s, input logic [5:0] f,
                          input int hold, input bit noise);
        logic [15:0] exp_r;
        logic [5:0]  exp_f;
        int          exp_lat;
        int          lat;
        int          w;
        if (refine_ok(a, f)) begin
            exp_r = ref_refine(a, s); exp_f = 6'd0; exp_lat = 2 * c_ITERS + 2;
        end else begin
            exp_r = s; exp_f = f; exp_lat = 1;
        end
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk); w++;
        end
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.A = a; bus.Aseed = s; bus.seedFlags = f;
        @(negedge clk);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            check("in_ready_busy", bus.in_ready, 0);
            if (noise) begin
                bus.in_valid  = 1'($urandom);
                bus.A         = 16'($urandom);
                bus.Aseed     = 16'($urandom);
                bus.seedFlags = 6'($urandom);
                bus.out_ready = 1'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk); lat++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_ready", bus.in_ready, 0);
            check("hold_arecip", bus.Arecip, exp_r);
            @(negedge clk);
        end
        check("out_valid", bus.out_valid, 1);
        check("arecip", bus.Arecip, exp_r);
        check("flags", bus.recipFlags, exp_f);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("ready_after_hs", bus.in_ready, 1);
        check("valid_after_hs", bus.out_valid, 0);
    endtask

    initial begin
        logic [15:0] a, s;
        logic [5:0]  f;
        int          ea, fa, q, kind;
        n_chk = 0; n_err = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.Aseed = '0; bus.seedFlags = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_arecip", bus.Arecip, 0);
        check("rst_flags", bus.recipFlags, 0);

        // Directed cases.
        run_op(16'h4040, 16'h3EA0, 6'd0, 0, 1'b0);
        check("three_exact", bus.Arecip, 16'h3EAB);
        run_op(16'hC040, 16'hBEA0, 6'd0, 0, 1'b0);
        check("neg_three_exact", bus.Arecip, 16'hBEAB);
        run_op(16'h3F80, 16'h3F80, 6'd0, 0, 1'b0);
        run_op(16'h7F80, 16'h0000, 6'b000100, 0, 1'b0);
        run_op(16'h4000, 16'h3F00, 6'd0, 0, 1'b0);
        run_op(16'h0000, 16'h7F80, 6'b000010, 1, 1'b0);
        run_op(16'h7E80, 16'h0080, 6'd0, 0, 1'b0);
        run_op(16'h7E40, 16'h0090, 6'd0, 0, 1'b0);
        run_op(16'h00FF, 16'h7E81, 6'd0, 0, 1'b0);
        run_op(16'h4040, 16'h3EA0, 6'd0, 5, 1'b0);
        check("bp_exact", bus.Arecip, 16'h3EAB);

        // Reset during the second P cycle drops the operation.
        bus.in_valid = 1'b1; bus.A = 16'h4040; bus.Aseed = 16'h3EA0; bus.seedFlags = '0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_arecip", bus.Arecip, 0);
        check("mid_rst_flags", bus.recipFlags, 0);
        rst = 1'b0;
        run_op(16'h4040, 16'h3EA0, 6'd0, 0, 1'b0);
        check("post_rst_exact", bus.Arecip, 16'h3EAB);

        // Randomized operands with seeds near 1/A.
        for (int n = 0; n < 1500; n++) begin
            kind = int'($urandom_range(0, 9));
            ea   = int'($urandom_range(1, 252));
            fa   = int'($urandom_range(1, 127));
            if (kind == 8) ea = int'($urandom_range(253, 255));
            if (kind == 9) fa = 0;
            q = 32768 / (128 + fa) - 128 + int'($urandom_range(0, 2));
            if (q > 127) q = 127;
            a = {1'($urandom), 8'(ea), 7'(fa)};
            s = {a[15], 8'(253 - ea), 7'(q)};
            f = 6'd0;
            if (kind == 7) begin
                s = 16'($urandom);
                f = 6'($urandom_range(1, 63));
            end
            run_op(a, s, f, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
